// File: rtl/hash_arb_pkg.sv
// Shared types and constants for the hash-unit arbiter.
package hash_arb_pkg;

  // Shared bus widths: keys travel on the quad bus, hash values on the data bus.
  localparam int unsigned QUAD_W     = 64;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEF_KEY_W  = QUAD_W;
  localparam int unsigned DEF_HASH_W = DATA_W;

  // Cycles with start held low after reset so an interrupted hash unit frees itself.
  localparam int unsigned SETTLE_CYCLES = 2;
  // Length of the issue phase; the unit's ready is ignored during it.
  localparam int unsigned ISSUE_CYCLES  = 1;

  typedef enum logic [2:0] {
    ST_SETTLE  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

endpackage

// File: rtl/hash_arbiter_rr.sv
// Round-robin selector: first set request searching upward from ptr+1 with wrap.
// Purely combinational; the priority pointer is owned by the caller.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int unsigned cand;

  // Rotating first-set search; the first hit after ptr wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid                  = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        idx                    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hash_arbiter.sv
// Shares one hash unit among NUM_REQ requesters: round-robin grant, start/ready
// sequencing, timeout abort, and a one-cycle done pulse back to the owner.
module hash_arbiter
  import hash_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned KEY_W   = DEF_KEY_W,
  parameter int unsigned HASH_W  = DEF_HASH_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*KEY_W-1:0] key_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     err_o,
  output logic [HASH_W-1:0]        hash_o,
  output logic                     busy_o,
  output logic                     hash_start_o,
  output logic [KEY_W-1:0]         hash_key_o,
  input  logic                     hash_ready_i,
  input  logic [HASH_W-1:0]        hash_val_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [SET_W-1:0] SET_RST  = SET_W'(SETTLE_CYCLES);
  // Abort on the edge where the incremented count would reach TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic               err_d, busy_d, start_d;
  logic [HASH_W-1:0]  hash_d;
  logic [KEY_W-1:0]   key_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic [KEY_W-1:0]   keys [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_key
    assign keys[g] = key_i[g*KEY_W +: KEY_W];
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_o;
    done_d   = '0;
    err_d    = 1'b0;
    hash_d   = hash_o;
    start_d  = hash_start_o;
    key_d    = hash_key_o;

    case (state_q)
      ST_SETTLE: begin
        start_d  = 1'b0;
        settle_d = settle_q - SET_W'(1);
        if (settle_q <= SET_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          key_d   = keys[arb_idx];
          start_d = 1'b1;
          ptr_d   = arb_idx;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Ready may still be asserted from the previous operation; ignore it here.
        tmo_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (hash_ready_i) begin
          hash_d  = hash_val_i;
          done_d  = gnt_o;
          start_d = 1'b0;
          state_d = ST_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          done_d  = gnt_o;
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_RELEASE: begin
        start_d = 1'b0;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        start_d = 1'b0;
        gnt_d   = '0;
        state_d = ST_SETTLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, pointer and registered outputs; reset aborts and re-enters SETTLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SETTLE;
      settle_q     <= SET_RST;
      tmo_q        <= '0;
      ptr_q        <= PTR_RST;
      gnt_o        <= '0;
      done_o       <= '0;
      err_o        <= 1'b0;
      hash_o       <= '0;
      busy_o       <= 1'b1;
      hash_start_o <= 1'b0;
      hash_key_o   <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      tmo_q        <= tmo_d;
      ptr_q        <= ptr_d;
      gnt_o        <= gnt_d;
      done_o       <= done_d;
      err_o        <= err_d;
      hash_o       <= hash_d;
      busy_o       <= busy_d;
      hash_start_o <= start_d;
      hash_key_o   <= key_d;
    end
  end

endmodule

// File: tb/tb_hash_arbiter.sv
// Self-checking bench for hash_arbiter with a behavioural hash-unit stub and a
// transaction-level reference model (rotating priority, byte-sum hash).
module tb_hash_arbiter;

  localparam int N   = 4;
  localparam int KW  = 64;
  localparam int HW  = 32;
  localparam int TMO = 15;

  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N*KW-1:0] key_i = '0;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic            err_o;
  logic [HW-1:0]   hash_o;
  logic            busy_o;
  logic            hash_start_o;
  logic [KW-1:0]   hash_key_o;
  logic            hash_ready_i = 1'b0;
  logic [HW-1:0]   hash_val_i   = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int            mdl_ptr    = N - 1;
  logic [HW-1:0] mdl_hash   = '0;
  int            last_grant = 0;
  logic [KW-1:0] tb_key [N];

  // Hash unit stub controls
  int            hu_st      = 0;   // 0 free, 1 busy, 2 done
  bit            hu_sticky  = 1'b0;
  bit            hu_never   = 1'b0;
  bit            hu_lowseen = 1'b0;
  logic [KW-1:0] hu_key     = '0;

  hash_arbiter #(
    .NUM_REQ (N),
    .KEY_W   (KW),
    .HASH_W  (HW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .key_i        (key_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .hash_o       (hash_o),
    .busy_o       (busy_o),
    .hash_start_o (hash_start_o),
    .hash_key_o   (hash_key_o),
    .hash_ready_i (hash_ready_i),
    .hash_val_i   (hash_val_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hash function of the unit: saturating sum of the key bytes.
  function automatic logic [HW-1:0] sat_sum(input logic [KW-1:0] k);
    int unsigned s = 0;
    for (int b = 0; b < KW / 8; b++) s += k[b*8 +: 8];
    return (s > 255) ? HW'(255) : HW'(s);
  endfunction

  // Rotating priority: first requester after the last winner.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int b = 0; b < KW / 8; b++) k[b*8 +: 8] = 8'($urandom_range(0, 40));
    return k;
  endfunction

  // Hash unit stub: one cycle of work, ready held until start drops (or, in
  // sticky mode, until the next start), never ready when hu_never is set.
  always @(posedge clk) begin
    case (hu_st)
      0: if (hash_start_o) begin
        hu_key <= hash_key_o;
        hu_st  <= 1;
      end
      1: if (!hash_start_o) begin
        hu_st <= 0;
      end else if (!hu_never) begin
        hash_ready_i <= 1'b1;
        hash_val_i   <= sat_sum(hu_key);
        hu_lowseen   <= 1'b0;
        hu_st        <= 2;
      end
      default: begin
        if (!hash_start_o) hu_lowseen <= 1'b1;
        if (!hu_sticky && !hash_start_o) begin
          hash_ready_i <= 1'b0;
          hu_st        <= 0;
        end else if (hu_sticky && hash_start_o && hu_lowseen) begin
          hash_ready_i <= 1'b0;
          hu_key       <= hash_key_o;
          hu_st        <= 1;
        end
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_keys();
    for (int i = 0; i < N; i++) key_i[i*KW +: KW] = tb_key[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_gnt",   64'(gnt_o),        64'd0);
    chk("rst_done",  64'(done_o),       64'd0);
    chk("rst_err",   64'(err_o),        64'd0);
    chk("rst_hash",  64'(hash_o),       64'd0);
    chk("rst_start", 64'(hash_start_o), 64'd0);
    chk("rst_key",   64'(hash_key_o),   64'd0);
    chk("rst_busy",  64'(busy_o),       64'd1);
    @(negedge clk);
    rst        = 1'b1;
    last_grant = cyc;
    mdl_ptr    = N - 1;
    mdl_hash   = '0;
  endtask

  // One complete transaction against the model; returns at the negedge after RELEASE.
  task automatic txn(input logic [N-1:0] mask, input int exp_lat, input bit exp_err,
                     input int exp_gap);
    int            w;
    int            t0;
    int            t1;
    bit            early;
    bit            held;
    logic [N-1:0]  g;
    logic [HW-1:0] exp_hash;
    w     = pick(mask, mdl_ptr);
    req_i = mask;
    t0    = -1;
    early = 1'b0;
    for (int k = 0; k < 40 && t0 < 0; k++) begin
      @(negedge clk);
      if (done_o != '0) early = 1'b1;
      if (gnt_o != '0) t0 = cyc;
    end
    chk("grant_seen", 64'(t0 >= 0), 64'd1);
    if (t0 < 0) return;
    chk("no_early_done", 64'(early), 64'd0);
    if (exp_gap > 0) chk("grant_gap", 64'(t0 - last_grant), 64'(exp_gap));
    last_grant = t0;
    chk("gnt",       64'(gnt_o),        64'(1 << w));
    chk("key",       64'(hash_key_o),   64'(tb_key[w]));
    chk("start_hi",  64'(hash_start_o), 64'd1);
    chk("busy_txn",  64'(busy_o),       64'd1);
    g    = gnt_o;
    held = 1'b1;
    t1   = -1;
    for (int k = 0; k < 40 && t1 < 0; k++) begin
      @(negedge clk);
      if (done_o != '0) t1 = cyc;
      else if (gnt_o !== g) held = 1'b0;
    end
    chk("done_seen", 64'(t1 >= 0), 64'd1);
    if (t1 < 0) return;
    exp_hash = exp_err ? mdl_hash : sat_sum(tb_key[w]);
    chk("latency",     64'(t1 - t0),      64'(exp_lat));
    chk("gnt_held",    64'(held),         64'd1);
    chk("done",        64'(done_o),       64'(1 << w));
    chk("gnt_at_done", 64'(gnt_o),        64'(1 << w));
    chk("hash",        64'(hash_o),       64'(exp_hash));
    chk("err",         64'(err_o),        64'(exp_err));
    chk("start_lo",    64'(hash_start_o), 64'd0);
    mdl_hash = exp_hash;
    mdl_ptr  = w;
    @(negedge clk);
    chk("done_clear", 64'(done_o), 64'd0);
    chk("err_clear",  64'(err_o),  64'd0);
    chk("gnt_clear",  64'(gnt_o),  64'd0);
    chk("hash_hold",  64'(hash_o), 64'(mdl_hash));
    chk("busy_idle",  64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            t0;
    logic [N-1:0]  mask;

    for (int i = 0; i < N; i++) tb_key[i] = '0;

    // Reset, then a single request after SETTLE
    tb_key[0] = 64'h0102030405060708;
    drive_keys();
    do_reset();
    chk("hash_model_0x24", 64'(sat_sum(tb_key[0])), 64'h24);
    txn(4'b0001, 3, 1'b0, 3);
    req_i = '0;

    // All four at once with all-ones keys; sticky ready carries into each ISSUE
    for (int i = 0; i < N; i++) tb_key[i] = '1;
    drive_keys();
    hu_sticky = 1'b1;
    do_reset();
    txn(4'b1111, 3, 1'b0, 3);
    txn(4'b1111, 3, 1'b0, 5);
    txn(4'b1111, 3, 1'b0, 5);
    txn(4'b1111, 3, 1'b0, 5);

    // Stale ready from the previous 0xFF result must not be forwarded
    tb_key[0] = 64'h0102030405060708;
    drive_keys();
    txn(4'b0001, 3, 1'b0, 5);
    req_i = '0;

    // Timeout: unit never raises ready
    hu_sticky = 1'b0;
    hu_never  = 1'b1;
    repeat (2) @(negedge clk);
    tb_key[1] = rand_key();
    drive_keys();
    txn(4'b0010, 1 + TMO, 1'b1, 0);
    req_i    = '0;
    hu_never = 1'b0;

    // Reset while WAIT: start drops at once, no done for the aborted owner
    tb_key[0] = rand_key();
    drive_keys();
    req_i = 4'b0001;
    t0    = -1;
    for (int k = 0; k < 20 && t0 < 0; k++) begin
      @(negedge clk);
      if (gnt_o != '0) t0 = cyc;
    end
    chk("mid_grant_seen", 64'(t0 >= 0), 64'd1);
    @(negedge clk);
    chk("mid_start_hi", 64'(hash_start_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_start_lo", 64'(hash_start_o), 64'd0);
    chk("mid_gnt",      64'(gnt_o),        64'd0);
    chk("mid_busy",     64'(busy_o),       64'd1);
    @(negedge clk);
    chk("mid_done", 64'(done_o), 64'd0);
    rst        = 1'b1;
    last_grant = cyc;
    mdl_ptr    = N - 1;
    mdl_hash   = '0;

    // Recovery plus held requests on 0 and 2: grants alternate 0,2,0,2
    tb_key[0] = rand_key();
    tb_key[2] = rand_key();
    drive_keys();
    txn(4'b0101, 3, 1'b0, 3);
    txn(4'b0101, 3, 1'b0, 5);
    txn(4'b0101, 3, 1'b0, 5);
    txn(4'b0101, 3, 1'b0, 5);

    // Randomized masks, keys and ready behaviour
    for (int r = 0; r < 12; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) tb_key[i] = rand_key();
      drive_keys();
      hu_sticky = 1'($urandom_range(0, 1));
      txn(mask, 3, 1'b0, 5);
    end
    req_i = '0;
    repeat (3) @(negedge clk);
    chk("final_idle_busy", 64'(busy_o), 64'd0);
    chk("final_gnt",       64'(gnt_o),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_arbiter.md
Name: hash_arbiter

Overview:
Shares one hash unit among NUM_REQ requesters and sequences the unit's start/ready handshake on their behalf. Each requester raises a level request with its key. The block grants round-robin, drives the hash unit, and returns the result with a one-cycle done pulse. It sits between the lookup-table clients and the single hash instance. It guarantees that no stale ready or stale value from the hash unit is ever forwarded.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
KEY_W, 64, key width (matches hash key input)
HASH_W, 32, hash value width (matches hash value output)
TIMEOUT, 15, max cycles in WAIT before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_i  in  NUM_REQ  per-requester level request
key_i  in  NUM_REQ*KEY_W  per-requester key; slice i = key_i[i*KEY_W +: KEY_W]
gnt_o  out  NUM_REQ  one-hot; current owner, held for the whole transaction
done_o  out  NUM_REQ  one-hot, one-cycle pulse to the owner when the result is valid
err_o  out  1  one-cycle pulse coincident with done_o on timeout abort
hash_o  out  HASH_W  result; valid only while done_o is non-zero, otherwise holds last value
busy_o  out  1  high in any state except IDLE
hash_start_o  out  1  to hash unit start
hash_key_o  out  KEY_W  to hash unit key
hash_ready_i  in  1  from hash unit ready
hash_val_i  in  HASH_W  from hash unit value

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) clears gnt_o, done_o, err_o, hash_o, hash_start_o and hash_key_o to 0, and sets busy_o=1.
  - It also sets state=SETTLE, settle counter=2, and rr pointer=NUM_REQ-1, so requester 0 has first priority.
- FSM states: SETTLE, IDLE, ISSUE, WAIT, RELEASE.
- SETTLE:
  - hash_start_o=0; counter decrements each cycle; goes to IDLE at 0.
  - Purpose: the hash unit can be mid-transaction when reset hits, and needs up to 2 cycles with start low to return to its free state.
- IDLE:
  - If any req_i is set, pick the first set bit searching from pointer+1 upward with wrap.
  - At the clock edge: set gnt_o to the winner, latch its key into hash_key_o, set hash_start_o=1, set pointer=winner, go to ISSUE.
  - No request: stay in IDLE with outputs unchanged.
- ISSUE (exactly 1 cycle):
  - hash_ready_i is ignored; it may still be high from the previous operation.
  - Timeout counter is cleared; go to WAIT.
- WAIT:
  - If hash_ready_i=1: capture hash_val_i into hash_o, pulse done_o=gnt_o, set hash_start_o=0, go to RELEASE.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT: behave as the ready case, but capture no value; hash_o keeps its old value and err_o pulses.
- RELEASE (exactly 1 cycle):
  - hash_start_o=0 so the hash unit leaves its done state.
  - Clear gnt_o; done_o returns to 0; go to IDLE.
- Latency:
  - Grant edge e0 (enter ISSUE); hash unit sees start at e1; ready and value valid after e2.
  - done_o and hash_o are visible in the cycle after e3.
  - Next grant no earlier than e5, giving 5-cycle throughput per transaction with nominal hash latency.
- Requester rules:
  - The key must be stable only at the grant edge.
  - req_i may be dropped after the done pulse. If it is still high in IDLE, it is re-arbitrated at lowest priority.
  - Dropping req_i mid-transaction does not cancel the transaction; done_o still pulses.
- Simultaneous requests resolve by rotating priority, so there is no starvation. Worst-case wait is (NUM_REQ-1) transactions.
- Reset mid-transaction aborts immediately. No done_o is issued for the aborted owner. The block returns via SETTLE.
- Width rule: hash_o is taken verbatim from hash_val_i, with no truncation or extension.

Decomposition:
- Package hash_arb_pkg holds:
  - state enum (SETTLE, IDLE, ISSUE, WAIT, RELEASE);
  - localparams SETTLE_CYCLES=2 and ISSUE_CYCLES=1;
  - default KEY_W/HASH_W mirroring the shared quad/data bus widths.
- Sub-module rr_arbiter (parameter N):
  - combinational first-set search from pointer+1;
  - outputs a one-hot grant and binary index;
  - the pointer register lives in hash_arbiter.

Test Plan:
- Reset then single request: req_i=4'b0001, key 0x0102030405060708, with the real hash unit attached.
  - Expect gnt_o=0001 after SETTLE, done_o=0001 exactly 3 cycles after the grant edge, hash_o=0x24, err_o=0.
- All four requesting at once, keys all 0xFF..FF:
  - Grants in order 0,1,2,3, each 5 cycles apart.
  - Each done_o carries hash_o=0xFF; no overlap of gnt_o.
- Stale ready: the previous result left hash_ready_i=1 into the next ISSUE.
  - No done_o in ISSUE; done only after the fresh ready.
  - hash_o matches the new key (0x24, not the previous 0xFF).
- Timeout: stub the hash unit so ready is never asserted.
  - done_o and err_o pulse together 1+TIMEOUT cycles after grant (16 by default), with hash_o unchanged.
  - hash_start_o drops; the block returns to IDLE.
- Reset mid-WAIT: assert rst=0 for 1 cycle while hash_start_o=1.
  - hash_start_o=0 immediately (asynchronously); no done_o is issued.
  - The block waits 2 SETTLE cycles, then requester 0 wins and gets a correct result.
- Held request: req_i[2] stays high continuously alongside req_i[0].
  - Grants alternate 0,2,0,2; requester 2 is never starved.
